alu_pipe: RTL and testbench

- Parametrised successor of the single-cycle combinational ALU.
- Operates on the same instruction fields: opc, op_type, op_a, op_b.
- Adds configurable DATA_W, valid/ready handshakes on input and output, an iterative shift-add multiplier, and overflow reporting.
- Sits between the instruction decode stage and the writeback stage; holds exactly one operation in flight.

---
 rtl/alu_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes: ADD/SUB/PASS_A complete in one cycle,
// MULT runs a DATA_W-cycle shift-add loop. Exactly one operation is held in flight.
module alu_pipe #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        opc,
    input  logic              op_type,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic              ovf,
    output logic              busy
);

    localparam int MSB = DATA_W - 1;
    localparam logic [1:0] OPC_ADD  = 2'd0;
    localparam logic [1:0] OPC_SUB  = 2'd1;
    localparam logic [1:0] OPC_MULT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0]    cnt;
    logic                neg;
    logic                sgn_r;

    logic                accept;
    logic                last_iter;
    logic [DATA_W:0]     add_sum;
    logic [DATA_W:0]     sub_diff;
    logic [DATA_W-1:0]   res;
    logic                res_ovf;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     acc_sum;
    logic [2*DATA_W-1:0] prod_next;
    logic [2*DATA_W-1:0] prod_final;
    logic                mult_ovf;

    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign last_iter = (state == S_BUSY) && (cnt == CNT_W'(DATA_W - 1));

    // Single-cycle operations, evaluated directly on the incoming fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        res      = op_a;
        res_ovf  = 1'b0;
        add_sum  = {1'b0, op_a} + {1'b0, op_b};
        sub_diff = {1'b0, op_a} - {1'b0, op_b};
        case (opc)
            OPC_ADD: begin
                res     = add_sum[MSB:0];
                res_ovf = op_type ? ((op_a[MSB] == op_b[MSB]) && (add_sum[MSB] != op_a[MSB]))
                                  : add_sum[DATA_W];
            end
            OPC_SUB: begin
                res     = sub_diff[MSB:0];
                res_ovf = op_type ? ((op_a[MSB] != op_b[MSB]) && (sub_diff[MSB] != op_a[MSB]))
                                  : sub_diff[DATA_W];
            end
            default: begin
                res     = op_a;
                res_ovf = 1'b0;
            end
        endcase
    end

    // Magnitudes are DATA_W wide so the most-negative operand maps to 2^(DATA_W-1).
    assign a_mag = (op_type && op_a[MSB]) ? -op_a : op_a;
    assign b_mag = (op_type && op_b[MSB]) ? -op_b : op_b;

    // Right-shifting product register: upper half accumulates, lower half holds the multiplier.
    always_comb begin
        acc_sum    = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next  = {acc_sum, prod[MSB:1]};
        prod_final = neg ? -prod_next : prod_next;
        mult_ovf   = sgn_r ? !((&prod_final[2*DATA_W-1:MSB]) || !(|prod_final[2*DATA_W-1:MSB]))
                           : (|prod_final[2*DATA_W-1:DATA_W]);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = (opc == OPC_MULT) ? S_BUSY : S_DONE;
            S_BUSY: if (last_iter) state_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) state_next = (opc == OPC_MULT) ? S_BUSY : S_DONE;
                    else          state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sgn_r   <= 1'b0;
            alu_out <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (opc == OPC_MULT) begin
                    mcand <= a_mag;
                    prod  <= {{DATA_W{1'b0}}, b_mag};
                    cnt   <= '0;
                    neg   <= op_type && (op_a[MSB] ^ op_b[MSB]);
                    sgn_r <= op_type;
                end else begin
                    alu_out <= res;
                    ovf     <= res_ovf;
                end
            end else if (state == S_BUSY) begin
                prod <= prod_next;
                cnt  <= cnt + CNT_W'(1);
                if (last_iter) begin
                    alu_out <= prod_final[MSB:0];
                    ovf     <= mult_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: single-cycle ops, MULT latency and boundaries,
// backpressure, and reset during a multiply.
module tb_alu_pipe;

    localparam int W = 24;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MULT = 2'd2, PASS = 2'd3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   opc;
    logic         op_type;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opc       (opc),
        .op_type   (op_type),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge; returns 1ns after that edge.
    task automatic issue(input logic [1:0] o, input logic t, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        opc      = o;
        op_type  = t;
        op_a     = a;
        op_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] exp_out, input logic exp_ovf);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out"}, 32'(alu_out), 32'(exp_out));
        check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    // Called right after a MULT accept edge: the result must appear exactly W edges later.
    task automatic wait_mult(input string tag);
        int bad = 0;
        for (int i = 1; i < W; i++) begin
            op_a = 24'h5A5A5A;
            op_b = 24'hA5A5A5;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        check({tag, ".busy_window"}, 32'(bad), 32'd0);
        tick();
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opc       = ADD;
        op_type   = 1'b0;
        op_a      = '0;
        op_b      = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.alu_out", 32'(alu_out), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);

        issue(ADD, 1'b0, 24'h000005, 24'h000003);
        check_result("add_u", 24'h000008, 1'b0);
        issue(SUB, 1'b0, 24'h000005, 24'h000003);
        check_result("sub_u", 24'h000002, 1'b0);
        issue(SUB, 1'b0, 24'h000003, 24'h000005);
        check_result("sub_u_borrow", 24'hFFFFFE, 1'b1);
        issue(ADD, 1'b1, 24'h7FFFFF, 24'h000001);
        check_result("add_s_ovf", 24'h800000, 1'b1);
        issue(SUB, 1'b1, 24'h800000, 24'h000001);
        check_result("sub_s_ovf", 24'h7FFFFF, 1'b1);
        issue(PASS, 1'b1, 24'h123456, 24'hFFFFFF);
        check_result("pass", 24'h123456, 1'b0);
        tick();
        check("idle.out_valid", 32'(out_valid), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);

        issue(MULT, 1'b0, 24'd12, 24'd3);
        wait_mult("mul_u");
        check_result("mul_u", 24'd36, 1'b0);
        issue(MULT, 1'b1, 24'hFFFFFC, 24'd6);
        wait_mult("mul_s");
        check_result("mul_s", 24'hFFFFE8, 1'b0);
        issue(MULT, 1'b0, 24'h001000, 24'h001000);
        wait_mult("mul_u_ovf");
        check_result("mul_u_ovf", 24'h000000, 1'b1);
        issue(MULT, 1'b1, 24'h800000, 24'h000001);
        wait_mult("mul_s_minneg");
        check_result("mul_s_minneg", 24'h800000, 1'b0);
        issue(MULT, 1'b1, 24'h800000, 24'hFFFFFF);
        wait_mult("mul_s_minneg_ovf");
        check_result("mul_s_minneg_ovf", 24'h800000, 1'b1);

        issue(ADD, 1'b0, 24'hFFFFFF, 24'h000002);
        check_result("add_u_carry", 24'h000001, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        opc       = ADD;
        op_type   = 1'b1;
        op_a      = 24'hFFFFFF;
        op_b      = 24'hFFFFFF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || alu_out !== 24'h000001 || ovf !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("stall.hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        #1;
        check("stall.in_ready_release", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_result("post_stall_add_s", 24'hFFFFFE, 1'b0);

        issue(MULT, 1'b0, 24'd7, 24'd9);
        repeat (9) tick();
        check("pre_rst.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.busy", 32'(busy), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        check("mid_rst.alu_out", 32'(alu_out), 32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("mid_rst.no_stale", 32'(bad), 32'd0);
        issue(ADD, 1'b0, 24'd1, 24'd1);
        check_result("add_after_rst", 24'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
